// File: rtl/axil_rd_mux.sv
// axil_rd_mux: four-master to one-slave AXI-Lite read multiplexer.
// An external round-robin arbiter picks the master; this block routes one
// AR/R transaction at a time to the shared slave and counts completions.
module axil_rd_mux #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    output logic [3:0]            arb_req,
    input  logic [3:0]            arb_grant,

    input  logic [3:0]            m_arvalid,
    output logic [3:0]            m_arready,
    input  logic [4*ADDR_W-1:0]   m_araddr,

    output logic [3:0]            m_rvalid,
    input  logic [3:0]            m_rready,
    output logic [4*DATA_W-1:0]   m_rdata,
    output logic [7:0]            m_rresp,

    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,

    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,

    output logic                  busy,
    output logic [15:0]           txn_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  grant_idx;
    logic        ar_hs;
    logic        r_hs;

    // Lowest set bit of the grant wins when the arbiter is not one-hot.
    always_comb begin
        grant_idx = 2'd0;
        if (arb_grant[0])      grant_idx = 2'd0;
        else if (arb_grant[1]) grant_idx = 2'd1;
        else if (arb_grant[2]) grant_idx = 2'd2;
        else if (arb_grant[3]) grant_idx = 2'd3;
    end

    // Pure combinational routing of the selected master; everything is forced low during reset.
    always_comb begin
        arb_req   = '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_rready  = 1'b0;
        if (!rst) begin
            m_rdata = {4{s_rdata}};
            m_rresp = {4{s_rresp}};
            case (state_q)
                // Request is masked in the grant cycle so the arbiter cannot grant twice.
                IDLE: if (arb_grant == '0) arb_req = m_arvalid;
                ADDR: begin
                    s_arvalid        = m_arvalid[sel_q];
                    s_araddr         = m_araddr[int'(sel_q)*ADDR_W +: ADDR_W];
                    m_arready[sel_q] = s_arready;
                end
                DATA: begin
                    m_rvalid[sel_q] = s_rvalid;
                    s_rready        = m_rready[sel_q];
                end
                default: ;
            endcase
        end
    end

    assign ar_hs   = s_arvalid && s_arready;
    assign r_hs    = s_rvalid && s_rready;
    assign busy    = !rst && (state_q != IDLE);
    assign txn_cnt = rst ? '0 : cnt_q;

    // Next-state, selected master and saturating completion count.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_grant != '0) begin
                    sel_d   = grant_idx;
                    state_d = ADDR;
                end
            end
            ADDR: if (ar_hs) state_d = DATA;
            DATA: begin
                if (r_hs) begin
                    state_d = IDLE;
                    if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; a grant seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_axil_rd_mux.sv
// Self-checking bench for axil_rd_mux: the bench plays arbiter, masters and
// slave, and predicts routing/counts at transaction level.
module tb_axil_rd_mux;

    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        arb_req;
    logic [3:0]        arb_grant;
    logic [3:0]        m_arvalid;
    logic [3:0]        m_arready;
    logic [4*AW-1:0]   m_araddr;
    logic [3:0]        m_rvalid;
    logic [3:0]        m_rready;
    logic [4*DW-1:0]   m_rdata;
    logic [7:0]        m_rresp;
    logic              s_arvalid;
    logic              s_arready;
    logic [AW-1:0]     s_araddr;
    logic              s_rvalid;
    logic              s_rready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              busy;
    logic [15:0]       txn_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    axil_rd_mux #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .arb_req(arb_req), .arb_grant(arb_grant),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .busy(busy), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic randomize_addrs();
        for (int i = 0; i < 4; i++) m_araddr[i*AW +: AW] = $urandom;
    endtask

    // One full read: grant, optional ADDR stall with arvalid low, AR wait, R wait.
    task automatic do_read(input logic [3:0] grant, input logic [3:0] junk,
                           input int gap, input int ar_wait, input int r_wait);
        int s;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0] rr;
        s = lowest(grant);
        randomize_addrs();
        a = m_araddr[s*AW +: AW];
        m_arvalid = 4'($urandom) | grant;
        arb_grant = '0;
        #1;
        total++; if (arb_req !== m_arvalid) begin bad++; $display("FAIL req_idle got=%b exp=%b", arb_req, m_arvalid); end
        arb_grant = grant;
        #1;
        total++; if (arb_req !== 4'b0) begin bad++; $display("FAIL req_gate got=%b exp=0000", arb_req); end
        total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL arvalid_grant got=%b exp=0", s_arvalid); end
        step();
        arb_grant = junk;
        for (int k = 0; k < gap; k++) begin
            m_arvalid[s] = 1'b0;
            s_arready = 1'b1;
            #1;
            total++; if (s_arvalid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL addr_gap got=%b/%b exp=0/1", s_arvalid, busy); end
            step();
        end
        m_arvalid[s] = 1'b1;
        for (int k = 0; k < ar_wait; k++) begin
            s_arready = 1'b0;
            #1;
            total++; if (s_arvalid !== 1'b1 || s_araddr !== a) begin bad++; $display("FAIL ar_stall got=%b/%h exp=1/%h", s_arvalid, s_araddr, a); end
            total++; if (m_arready !== 4'b0 || arb_req !== 4'b0) begin bad++; $display("FAIL ar_stall_rdy got=%b/%b exp=0000/0000", m_arready, arb_req); end
            step();
        end
        s_arready = 1'b1;
        #1;
        total++; if (s_arvalid !== 1'b1 || s_araddr !== a) begin bad++; $display("FAIL ar_hs got=%b/%h exp=1/%h", s_arvalid, s_araddr, a); end
        total++; if (m_arready !== onehot(s)) begin bad++; $display("FAIL ar_ready got=%b exp=%b", m_arready, onehot(s)); end
        total++; if (m_rvalid !== 4'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL r_idle_in_addr got=%b/%b exp=0000/0", m_rvalid, s_rready); end
        step();
        s_arready = 1'b0;
        d = $urandom;
        rr = 2'($urandom);
        s_rdata = d;
        s_rresp = rr;
        s_rvalid = 1'b1;
        for (int k = 0; k < r_wait; k++) begin
            m_rready = 4'($urandom) & ~onehot(s);
            #1;
            total++; if (m_rvalid !== onehot(s) || s_rready !== 1'b0) begin bad++; $display("FAIL r_stall got=%b/%b exp=%b/0", m_rvalid, s_rready, onehot(s)); end
            total++; if (s_arvalid !== 1'b0 || m_arready !== 4'b0) begin bad++; $display("FAIL ar_in_data got=%b/%b exp=0/0000", s_arvalid, m_arready); end
            step();
        end
        m_rready = 4'($urandom) | onehot(s);
        #1;
        total++; if (s_rready !== 1'b1 || m_rvalid !== onehot(s)) begin bad++; $display("FAIL r_hs got=%b/%b exp=1/%b", s_rready, m_rvalid, onehot(s)); end
        total++; if (m_rdata[s*DW +: DW] !== d || m_rresp[s*2 +: 2] !== rr) begin bad++; $display("FAIL r_data got=%h/%b exp=%h/%b", m_rdata[s*DW +: DW], m_rresp[s*2 +: 2], d, rr); end
        step();
        exp_cnt = (exp_cnt + 1 > 65535) ? 65535 : exp_cnt + 1;
        s_rvalid = 1'b0;
        m_rready = '0;
        arb_grant = '0;
        #1;
        total++; if (busy !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL back_idle got=%b/%b exp=0/0", busy, s_rready); end
        total++; if (txn_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL txn_cnt got=%h exp=%h", txn_cnt, 16'(exp_cnt)); end
        total++; if (arb_req !== m_arvalid) begin bad++; $display("FAIL req_back got=%b exp=%b", arb_req, m_arvalid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_arvalid = 4'b1011;
        arb_grant = 4'b0010;
        step();
        #1;
        total++; if (arb_req !== 4'b0 || busy !== 1'b0 || s_arvalid !== 1'b0) begin bad++; $display("FAIL rst_out got=%b/%b/%b exp=0000/0/0", arb_req, busy, s_arvalid); end
        total++; if (txn_cnt !== 16'h0 || m_rvalid !== 4'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL rst_out2 got=%h/%b/%b exp=0/0/0", txn_cnt, m_rvalid, s_rready); end
        step();
        rst = 1'b0;
        arb_grant = '0;
        #1;
        total++; if (busy !== 1'b0 || arb_req !== m_arvalid) begin bad++; $display("FAIL rst_grant_ignored got=%b/%b exp=0/%b", busy, arb_req, m_arvalid); end
        exp_cnt = 0;
    endtask

    task automatic test_single();
        do_read(4'b0100, 4'b0000, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        do_read(4'b0001, 4'b0010, 0, 1, 1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        do_read(4'b1000, 4'b0000, 2, 5, 3);
    endtask

    task automatic test_non_onehot();
        do_read(4'b1010, 4'b0000, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0] g;
        for (int n = 0; n < 20; n++) begin
            g = 4'($urandom_range(1, 15));
            do_read(g, 4'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_in_data();
        m_arvalid = 4'b0001;
        arb_grant = 4'b0001;
        step();
        arb_grant = '0;
        s_arready = 1'b1;
        step();
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        m_rready = 4'b0000;
        #1;
        total++; if (busy !== 1'b1 || m_rvalid !== 4'b0001) begin bad++; $display("FAIL in_data got=%b/%b exp=1/0001", busy, m_rvalid); end
        rst = 1'b1;
        m_rready = 4'b0001;
        #1;
        total++; if (m_rvalid !== 4'b0 || s_rready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_data_out got=%b/%b/%b exp=0000/0/0", m_rvalid, s_rready, busy); end
        step();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        total++; if (busy !== 1'b0 || s_rready !== 1'b0 || txn_cnt !== 16'h0) begin bad++; $display("FAIL rst_data_after got=%b/%b/%h exp=0/0/0", busy, s_rready, txn_cnt); end
        total++; if (arb_req !== m_arvalid) begin bad++; $display("FAIL rst_data_req got=%b exp=%b", arb_req, m_arvalid); end
        s_rvalid = 1'b0;
        m_rready = '0;
        step();
    endtask

    task automatic test_saturation();
        force dut.cnt_q = 16'hFFFE;
        step();
        release dut.cnt_q;
        exp_cnt = 65534;
        #1;
        total++; if (txn_cnt !== 16'hFFFE) begin bad++; $display("FAIL preload got=%h exp=fffe", txn_cnt); end
        for (int n = 0; n < 3; n++) do_read(onehot(n), 4'b0000, 0, 0, 0);
        total++; if (txn_cnt !== 16'hFFFF) begin bad++; $display("FAIL saturate got=%h exp=ffff", txn_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        arb_grant = '0;
        m_arvalid = '0;
        m_araddr = '0;
        m_rready = '0;
        s_arready = 1'b0;
        s_rvalid = 1'b0;
        s_rdata = '0;
        s_rresp = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_non_onehot();
        test_random();
        test_reset_in_data();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_rd_mux.md
AXIL_RD_MUX -- requirements
Module: axil_rd_mux

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, read address width.
REQ-002 SHALL have parameter DATA_W, default 32, read data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port arb_req  output  4  per-master request vector to the round-robin arbiter.
REQ-006 SHALL have port arb_grant  input  4  registered one-hot grant pulse from the arbiter.
REQ-007 SHALL have ports m_arvalid (input, 4), m_arready (output, 4), m_araddr (input, 4*ADDR_W): per-master AR channels, master i in bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have ports m_rvalid (output, 4), m_rready (input, 4), m_rdata (output, 4*DATA_W), m_rresp (output, 8): per-master R channels, packed as for AR.
REQ-009 SHALL have ports s_arvalid (output, 1), s_arready (input, 1), s_araddr (output, ADDR_W): downstream slave AR channel.
REQ-010 SHALL have ports s_rvalid (input, 1), s_rready (output, 1), s_rdata (input, DATA_W), s_rresp (input, 2): downstream slave R channel.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.
REQ-012 SHALL have port txn_cnt  output  16  count of completed read transactions.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-014 SHALL drive arb_req = m_arvalid only in IDLE while arb_grant == 0, and 4'b0 otherwise (combinational gate, so the arbiter cannot issue a second grant in the cycle after the first).
REQ-015 SHALL, in IDLE with arb_grant != 0, latch the selected index into a 2-bit sel register and enter ADDR next cycle.
REQ-016 SHALL select the lowest set bit if arb_grant is not one-hot.
REQ-017 SHALL ignore arb_grant in ADDR and DATA.
REQ-018 SHALL, in ADDR, drive s_arvalid = m_arvalid[sel], s_araddr = m_araddr[sel] and m_arready[sel] = s_arready, with all other m_arready low.
REQ-019 SHALL move ADDR to DATA on the cycle where s_arvalid && s_arready.
REQ-020 SHALL, in DATA, drive m_rvalid[sel] = s_rvalid and s_rready = m_rready[sel], with all other m_rvalid low.
REQ-021 SHALL broadcast s_rdata/s_rresp to all m_rdata/m_rresp lanes; only the m_rvalid qualifies them.
REQ-022 SHALL move DATA to IDLE on the cycle where s_rvalid && s_rready.
REQ-023 SHALL hold s_arvalid = 0 outside ADDR and s_rready = 0 outside DATA.
REQ-024 SHALL produce a latency of one cycle from an arb_grant pulse to s_arvalid, and zero added latency on AR and R handshakes (pure combinational routing).
REQ-025 SHALL make arb_req visible again the first cycle back in IDLE; the minimum spacing between transactions is therefore 4 cycles (IDLE, grant, ADDR, DATA).
REQ-026 SHALL increment txn_cnt by 1 on each R handshake and saturate at 16'hFFFF.
REQ-027 SHALL accept a granted master whose m_arvalid is low in ADDR by waiting in ADDR; there is no timeout.

Reset
REQ-028 SHALL, with rst high at a clk edge, set state = IDLE, sel = 0 and txn_cnt = 0.
REQ-029 SHALL hold all outputs low during reset, including in-flight transactions, which are abandoned without completion.
REQ-030 SHALL ignore arb_grant in the cycle rst is high.

Verification
REQ-031 Single read: m_arvalid = 4'b0100, grant 4'b0100 at cycle N -> s_arvalid = 1 at N+1 with m_araddr lane 2; R handshake routes s_rdata to m_rvalid[2]; txn_cnt 0 -> 1.
REQ-032 Back-to-back grant: arb_grant = 4'b0001 then 4'b0010 on consecutive cycles -> only master 0 is served and arb_req = 0 during the grant cycle.
REQ-033 Backpressure: s_arready low 5 cycles, then m_rready[sel] low 3 cycles -> state holds ADDR then DATA, no duplicate handshake, other m_arready/m_rvalid stay 0.
REQ-034 Non-one-hot grant 4'b1010 -> sel = 1.
REQ-035 Reset in DATA: rst high for 1 cycle -> next cycle busy = 0, s_rready = 0, txn_cnt = 0, arb_req = m_arvalid.
REQ-036 Saturation: preload txn_cnt to 16'hFFFE, run 3 reads -> txn_cnt = 16'hFFFF.
